tv80_reg_dbg: RTL
=================

Name: tv80_reg_dbg

Overview:
Debug snapshot/restore sequencer for the TV80 register file (8 entries of H/L byte pairs, one write/read-A port, combinational read).
- Sits between the core and the register file's A port.
- On request, takes the A port from the core at an instruction boundary, then streams all register pairs out (dump) or in (load) over a valid/ready interface.
- Returns the port to the core when finished.

Parameters:
NREGS, 8, number of register-pair entries sequenced (indices 0..NREGS-1)
AW, 3, register address width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
core_AddrA  input  AW  core A-port address
core_DIH  input  8  core high write data
core_DIL  input  8  core low write data
core_WEH  input  1  core high write enable
core_WEL  input  1  core low write enable
core_CEN  input  1  core clock enable
core_idle  input  1  core is at an instruction boundary, safe to steal port
core_hold  output  1  stall request to core
core_conflict  output  1  pulse: core write attempted while port owned by sequencer
AddrA  output  AW  to register file
DIH  output  8  to register file
DIL  output  8  to register file
WEH  output  1  to register file
WEL  output  1  to register file
CEN  output  1  to register file
DOAH  input  8  register file read data, high
DOAL  input  8  register file read data, low
dbg_start  input  1  start pulse, sampled in IDLE only
dbg_load  input  1  with dbg_start: 1 = load, 0 = dump
dbg_abort  input  1  abort current operation
dump_data  output  16  {DOAH,DOAL} of current index
dump_valid  output  1  dump word valid
dump_ready  input  1  consumer accepts dump word
load_data  input  16  {H,L} word to write
load_valid  input  1  load word valid
load_ready  output  1  sequencer accepts load word
dbg_busy  output  1  state != IDLE
dbg_done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE, idx=0, mode=0, core_hold=0, core_conflict=0, dbg_done=0. Mux selects the core, so port outputs equal core inputs.
- States: IDLE, HOLD, DUMP, LOAD, DONE.
- IDLE: dbg_start=1 latches mode=dbg_load, sets idx=0, goes to HOLD. dbg_start in any other state is ignored.
- HOLD: core_hold=1 and the core still owns the port. When core_idle=1, go to DUMP (mode 0) or LOAD (mode 1) next cycle.
- DUMP:
  - core_hold=1; AddrA=idx; WEH=WEL=0; CEN=1.
  - dump_valid=1 combinationally; dump_data={DOAH,DOAL}, zero-latency read.
  - On dump_valid&dump_ready: idx+1. If idx==NREGS-1, go to DONE instead.
- LOAD:
  - core_hold=1; load_ready=1; AddrA=idx; DIH=load_data[15:8]; DIL=load_data[7:0].
  - WEH=WEL=CEN=load_valid, so the write lands on the same rising edge as acceptance.
  - On accept: idx+1. If idx==NREGS-1, go to DONE.
- DONE: dbg_done=1 for exactly one cycle; core_hold=0; mux back to core; next state IDLE; idx=0.
- The mux selects the sequencer only in DUMP and LOAD. In IDLE, HOLD and DONE the port outputs pass the core inputs unchanged.
- dump_valid and load_ready are 0 outside DUMP and LOAD respectively.
- Core write while owned: in DUMP/LOAD, core_CEN&(core_WEH|core_WEL) gives core_conflict=1 (registered, next cycle, one cycle per occurrence). Core data is discarded.
- dbg_abort in HOLD/DUMP/LOAD: go to IDLE next cycle with no dbg_done and idx=0. A write accepted in the same cycle as abort still commits. Abort has priority over the DONE transition.
- dbg_abort in IDLE or DONE: ignored.
- Stalled handshakes: dump_ready or load_valid low holds idx and state indefinitely. AddrA is stable while dump_valid=1.
- idx is AW+1 bits wide internally, and compares against NREGS-1 with no wrap.
- Reset asserted mid-operation: immediate IDLE, core_hold drops asynchronously, partial load is not rolled back.

Test Plan:
- Reset mid-LOAD after 3 words: core_hold→0 async, dbg_busy=0; entries 0..2 hold the new values, 3..7 unchanged.
- Dump with preloaded regs (entry i = 16'h1100+i*16'h0101), dump_ready always 1, core_idle=1 → words 1100,1201,…,1807 on 8 consecutive cycles. dbg_done pulses 1 cycle later, total start→done 11 cycles.
- Load 8 words 16'hA000+i with load_valid toggling every other cycle → exactly 8 writes at idx 0..7. A subsequent dump returns A000..A007; dbg_done=1 once.
- core_idle held low 5 cycles after start → remains in HOLD with core_hold=1, no port takeover. Core writes in HOLD reach the register file and core_conflict stays 0.
- Core write (core_CEN=1, core_WEL=1) during DUMP → register file WEL=0, core_conflict=1 next cycle, dumped data unaffected.
- dbg_abort during DUMP at idx=4 → IDLE next cycle, no dbg_done. A new dbg_start then restarts at idx 0.

Source files
------------

// File: rtl/tv80_reg_dbg.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tv80_reg_dbg
//
// Debug snapshot/restore sequencer for the TV80 register file A port.
// Sits between the core and the register file. On request it stalls the core,
// waits for an instruction boundary, then takes over the A port and either
// streams every register pair out (dump) or writes a stream of pairs in
// (load) over a valid/ready interface. The port is handed back afterwards.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   core_*                core side of the A port (address, data, enables)
//   core_idle             core is at an instruction boundary
//   core_hold             stall request to the core
//   core_conflict         one-cycle pulse: core tried to write while the
//                         sequencer owned the port (the write is dropped)
//   AddrA/DIH/DIL/
//   WEH/WEL/CEN           register file side of the A port
//   DOAH/DOAL             register file combinational read data
//   dbg_start/dbg_load    start an operation (1 = load, 0 = dump)
//   dbg_abort             abandon the current operation
//   dump_data/valid/ready dump stream, {H,L} of the current index
//   load_data/valid/ready load stream, {H,L} word to write
//   dbg_busy, dbg_done    status: not idle / one-cycle completion pulse
// ---------------------------------------------------------------------------
module tv80_reg_dbg #(
  parameter int NREGS = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  // core side
  input  logic [AW-1:0] core_AddrA,
  input  logic [7:0]    core_DIH,
  input  logic [7:0]    core_DIL,
  input  logic          core_WEH,
  input  logic          core_WEL,
  input  logic          core_CEN,
  input  logic          core_idle,
  output logic          core_hold,
  output logic          core_conflict,
  // register file side
  output logic [AW-1:0] AddrA,
  output logic [7:0]    DIH,
  output logic [7:0]    DIL,
  output logic          WEH,
  output logic          WEL,
  output logic          CEN,
  input  logic [7:0]    DOAH,
  input  logic [7:0]    DOAL,
  // debug control
  input  logic          dbg_start,
  input  logic          dbg_load,
  input  logic          dbg_abort,
  // dump stream
  output logic [15:0]   dump_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  // load stream
  input  logic [15:0]   load_data,
  input  logic          load_valid,
  output logic          load_ready,
  // status
  output logic          dbg_busy,
  output logic          dbg_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    DUMP = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } stateT;

  // idx carries one spare bit so the terminal compare never sees a wrapped
  // value, whatever NREGS is relative to 2**AW.
  localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);
  localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);

  stateT       state;
  stateT       stateNext;
  logic [AW:0] idx;
  logic [AW:0] idxNext;
  logic        mode;
  logic        modeNext;
  logic        conflictNext;

  logic        owned;      // sequencer drives the register file port
  logic        dumpFire;   // dump word handed over this cycle
  logic        loadFire;   // load word written this cycle
  logic        atLast;

  assign owned    = (state == DUMP) || (state == LOAD);
  assign dumpFire = (state == DUMP) && dump_ready;
  assign loadFire = (state == LOAD) && load_valid;
  assign atLast   = (idx == LAST_IDX);

  // -------------------------------------------------------------------------
  // State, index and mode registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= stateNext;
      idx   <= idxNext;
      mode  <= modeNext;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Abort is checked before the handshake so that it wins
  // over the DONE transition; a load write presented in the abort cycle
  // still reaches the register file because the write strobes below are
  // purely combinational.
  // -------------------------------------------------------------------------
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    modeNext  = mode;
    case (state)
      IDLE: begin
        if (dbg_start) begin
          modeNext  = dbg_load;
          idxNext   = '0;
          stateNext = HOLD;
        end
      end
      HOLD: begin
        if (dbg_abort) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else if (core_idle) begin
          stateNext = mode ? LOAD : DUMP;
        end
      end
      DUMP: begin
        if (dbg_abort) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else if (dumpFire) begin
          if (atLast) stateNext = DONE;
          else        idxNext   = idx + IDX_ONE;
        end
      end
      LOAD: begin
        if (dbg_abort) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else if (loadFire) begin
          if (atLast) stateNext = DONE;
          else        idxNext   = idx + IDX_ONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
      default: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Port mux. The core owns the port in every state except DUMP and LOAD.
  // -------------------------------------------------------------------------
  always_comb begin
    AddrA      = core_AddrA;
    DIH        = core_DIH;
    DIL        = core_DIL;
    WEH        = core_WEH;
    WEL        = core_WEL;
    CEN        = core_CEN;
    dump_valid = 1'b0;
    load_ready = 1'b0;
    case (state)
      DUMP: begin
        // Read-only access; the file's read path is combinational so the
        // word for idx is available in the same cycle.
        AddrA      = idx[AW-1:0];
        DIH        = 8'h00;
        DIL        = 8'h00;
        WEH        = 1'b0;
        WEL        = 1'b0;
        CEN        = 1'b1;
        dump_valid = 1'b1;
      end
      LOAD: begin
        // Always ready, so the write lands on the accepting clock edge.
        AddrA      = idx[AW-1:0];
        DIH        = load_data[15:8];
        DIL        = load_data[7:0];
        WEH        = load_valid;
        WEL        = load_valid;
        CEN        = load_valid;
        load_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Conflict flag: a core write attempt while the port is taken is dropped
  // and reported one cycle later, one pulse per attempted cycle.
  // -------------------------------------------------------------------------
  assign conflictNext = owned && core_CEN && (core_WEH || core_WEL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) core_conflict <= 1'b0;
    else       core_conflict <= conflictNext;
  end

  // -------------------------------------------------------------------------
  // Status outputs. core_hold is decoded from state so it drops as soon as
  // reset forces the state back to IDLE.
  // -------------------------------------------------------------------------
  assign core_hold = (state == HOLD) || owned;
  assign dbg_busy  = (state != IDLE);
  assign dbg_done  = (state == DONE);
  assign dump_data = {DOAH, DOAL};

endmodule
